pipe_stage_reg: RTL and testbench

PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

---
 rtl/pipe_stage_reg.sv | 177 +++++++++++++++++
 tb/tb_pipe_stage_reg.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_reg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_stage_reg
// Description : Valid/ready pipeline stage register with optional two-entry
//               skid buffer, flush kill, bubble insertion and saturating
//               stall / flush statistics counters.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_stage_reg #(
  parameter int unsigned           DATA_W  = 64,
  parameter int unsigned           SKID_EN = 1,
  parameter logic [DATA_W-1:0]     NOP_VAL = '0,
  parameter int unsigned           CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Stage view shared by both storage variants
  logic              w_out_valid;
  logic              w_in_ready;
  logic [DATA_W-1:0] w_head_data;
  logic              w_in_xfer;

  assign w_in_xfer = in_valid && w_in_ready;

  generate
    if (SKID_EN != 0) begin : g_skid
      typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL  = 2'd1,
        ST_SKID  = 2'd2
      } state_t;

      state_t            state_q, state_d;
      logic [DATA_W-1:0] main_q, main_d;
      logic [DATA_W-1:0] skid_q, skid_d;
      logic              in_ready_q;
      logic              w_out_xfer;

      assign w_out_xfer = (state_q != ST_EMPTY) && out_ready;

      // Next-state and payload movement; flush wins over every transfer
      always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        case (state_q)
          ST_EMPTY: begin
            if (w_in_xfer) begin
              state_d = ST_FULL;
              main_d  = in_data;
            end
          end
          ST_FULL: begin
            if (w_in_xfer && w_out_xfer) begin
              main_d = in_data;
            end else if (w_out_xfer) begin
              state_d = ST_EMPTY;
            end else if (w_in_xfer) begin
              state_d = ST_SKID;
              skid_d  = in_data;
            end
          end
          ST_SKID: begin
            if (w_out_xfer) begin
              state_d = ST_FULL;
              main_d  = skid_q;
            end
          end
          default: state_d = ST_EMPTY;
        endcase
        if (flush) begin
          state_d = ST_EMPTY;
        end
      end

      // State registers; in_ready is precomputed from the next state so it
      // leaves the stage straight from a flop
      always_ff @(posedge clk) begin
        if (rst) begin
          state_q    <= ST_EMPTY;
          main_q     <= NOP_VAL;
          skid_q     <= NOP_VAL;
          in_ready_q <= 1'b1;
        end else begin
          state_q    <= state_d;
          main_q     <= main_d;
          skid_q     <= skid_d;
          in_ready_q <= (state_d != ST_SKID);
        end
      end

      assign w_out_valid = (state_q != ST_EMPTY);
      assign w_in_ready  = in_ready_q;
      assign w_head_data = main_q;
    end else begin : g_single
      logic              valid_q, valid_d;
      logic [DATA_W-1:0] data_q, data_d;

      // Single entry: refill on any input transfer, empty on a bare output
      always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (w_in_xfer) begin
          valid_d = 1'b1;
          data_d  = in_data;
        end else if (valid_q && out_ready) begin
          valid_d = 1'b0;
        end
        if (flush) begin
          valid_d = 1'b0;
        end
      end

      // Single-entry storage
      always_ff @(posedge clk) begin
        if (rst) begin
          valid_q <= 1'b0;
          data_q  <= NOP_VAL;
        end else begin
          valid_q <= valid_d;
          data_q  <= data_d;
        end
      end

      assign w_out_valid = valid_q;
      assign w_in_ready  = !valid_q || out_ready;
      assign w_head_data = data_q;
    end
  endgenerate

  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  // Saturating statistics; a flush only counts if it actually killed a payload
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (w_out_valid && !out_ready && (stall_cnt_q != CNT_MAX)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
    if (flush && (w_out_valid || w_in_xfer) && (flush_cnt_q != CNT_MAX)) begin
      flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end
  end

  // Counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign in_ready  = w_in_ready;
  assign out_valid = w_out_valid;
  assign out_data  = w_out_valid ? w_head_data : NOP_VAL;
  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_reg.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_stage_reg
// Description : Self-checking bench for pipe_stage_reg. A skid instance and a
//               single-entry instance (2-bit counters) share one stimulus
//               stream and are compared against queue-based reference models.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_stage_reg;

  localparam int          DW      = 16;
  localparam logic [15:0] NOP_S   = 16'hBEEF;
  localparam logic [15:0] NOP_1   = 16'h5A5A;
  localparam int          MAX_S   = 65535;
  localparam int          MAX_1   = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          flush = 1'b0;
  logic          out_ready = 1'b0;

  logic          s_in_ready, s_out_valid;
  logic [DW-1:0] s_out_data;
  logic [15:0]   s_stall, s_flush;
  logic          o_in_ready, o_out_valid;
  logic [DW-1:0] o_out_data;
  logic [1:0]    o_stall, o_flush;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  pipe_stage_reg #(.DATA_W(DW), .SKID_EN(1), .NOP_VAL(NOP_S), .CNT_W(16)) u_skid (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(s_in_ready),
    .in_data(in_data), .flush(flush), .out_valid(s_out_valid),
    .out_ready(out_ready), .out_data(s_out_data),
    .stall_cnt(s_stall), .flush_cnt(s_flush)
  );

  pipe_stage_reg #(.DATA_W(DW), .SKID_EN(0), .NOP_VAL(NOP_1), .CNT_W(2)) u_single (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(o_in_ready),
    .in_data(in_data), .flush(flush), .out_valid(o_out_valid),
    .out_ready(out_ready), .out_data(o_out_data),
    .stall_cnt(o_stall), .flush_cnt(o_flush)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: each stage is a FIFO of capacity 2 (skid) or 1 (single)
  logic [DW-1:0] qs[$];
  logic [DW-1:0] q1[$];
  int stall_s = 0, flush_s = 0, stall_1 = 0, flush_1 = 0;

  always @(posedge clk) begin : model
    bit ov, ix;
    // skid stage
    ov = (qs.size() > 0);
    ix = in_valid && (qs.size() < 2);
    if (rst) begin
      qs.delete(); stall_s = 0; flush_s = 0;
    end else begin
      if (ov && !out_ready && stall_s < MAX_S) stall_s++;
      if (flush) begin
        if ((ov || ix) && flush_s < MAX_S) flush_s++;
        qs.delete();
      end else begin
        if (ov && out_ready) void'(qs.pop_front());
        if (ix) qs.push_back(in_data);
      end
    end
    // single-entry stage
    ov = (q1.size() > 0);
    ix = in_valid && (q1.size() == 0 || out_ready);
    if (rst) begin
      q1.delete(); stall_1 = 0; flush_1 = 0;
    end else begin
      if (ov && !out_ready && stall_1 < MAX_1) stall_1++;
      if (flush) begin
        if ((ov || ix) && flush_1 < MAX_1) flush_1++;
        q1.delete();
      end else begin
        if (ov && out_ready) void'(q1.pop_front());
        if (ix) q1.push_back(in_data);
      end
    end
  end

  // Compare both DUTs against the model every cycle, away from the edge
  always @(negedge clk) begin
    if (chk_en) begin
      chk("skid_valid", 32'(s_out_valid), 32'(qs.size() > 0));
      chk("skid_data", 32'(s_out_data), 32'((qs.size() > 0) ? qs[0] : NOP_S));
      chk("skid_in_ready", 32'(s_in_ready), 32'(qs.size() < 2));
      chk("skid_stall", 32'(s_stall), 32'(stall_s));
      chk("skid_flush", 32'(s_flush), 32'(flush_s));
      chk("single_valid", 32'(o_out_valid), 32'(q1.size() > 0));
      chk("single_data", 32'(o_out_data), 32'((q1.size() > 0) ? q1[0] : NOP_1));
      chk("single_in_ready", 32'(o_in_ready), 32'(q1.size() == 0 || out_ready));
      chk("single_stall", 32'(o_stall), 32'(stall_1));
      chk("single_flush", 32'(o_flush), 32'(flush_1));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [DW-1:0] d, input logic r, input logic f);
    in_valid = v; in_data = d; out_ready = r; flush = f;
  endtask

  initial begin
    // Reset values
    drive(1'b0, '0, 1'b0, 1'b0);
    rst = 1'b1;
    tick();
    chk_en = 1'b1;
    tick();
    chk("rst_valid", 32'(s_out_valid), 32'd0);
    chk("rst_in_ready", 32'(s_in_ready), 32'd1);
    chk("rst_data", 32'(s_out_data), 32'hBEEF);
    chk("rst_stall", 32'(s_stall), 32'd0);
    chk("rst_flush", 32'(s_flush), 32'd0);

    // Streaming with downstream always ready: latency 1, no stalls
    rst = 1'b0;
    drive(1'b1, 16'h000A, 1'b1, 1'b0);
    tick();
    chk("stream_lat1_valid", 32'(s_out_valid), 32'd1);
    chk("stream_lat1_data", 32'(s_out_data), 32'h000A);
    tick(); tick();
    chk("stream_data", 32'(s_out_data), 32'h000A);
    chk("stream_stall", 32'(s_stall), 32'd0);

    // Fill skid buffer under backpressure, then drain in order
    drive(1'b0, '0, 1'b1, 1'b0);
    tick();
    drive(1'b1, 16'h0001, 1'b0, 1'b0);
    tick();
    chk("fill1_in_ready", 32'(s_in_ready), 32'd1);
    drive(1'b1, 16'h0002, 1'b0, 1'b0);
    tick();
    chk("fill2_in_ready", 32'(s_in_ready), 32'd0);
    chk("fill2_data", 32'(s_out_data), 32'h0001);
    chk("fill2_stall", 32'(s_stall), 32'd1);
    drive(1'b1, 16'h0005, 1'b0, 1'b0);
    tick();
    chk("hold_data", 32'(s_out_data), 32'h0001);
    chk("hold_stall", 32'(s_stall), 32'd2);
    drive(1'b0, '0, 1'b1, 1'b0);
    tick();
    chk("drain1_data", 32'(s_out_data), 32'h0002);
    chk("drain1_in_ready", 32'(s_in_ready), 32'd1);
    tick();
    chk("drain2_valid", 32'(s_out_valid), 32'd0);

    // Flush from SKID with a simultaneous input
    drive(1'b1, 16'h0001, 1'b0, 1'b0);
    tick();
    drive(1'b1, 16'h0002, 1'b0, 1'b0);
    tick();
    drive(1'b1, 16'h0003, 1'b0, 1'b1);
    tick();
    chk("flush_valid", 32'(s_out_valid), 32'd0);
    chk("flush_data", 32'(s_out_data), 32'hBEEF);
    chk("flush_in_ready", 32'(s_in_ready), 32'd1);
    chk("flush_cnt", 32'(s_flush), 32'd1);
    drive(1'b0, '0, 1'b1, 1'b0);
    tick(); tick();
    chk("flush_no3", 32'(s_out_valid), 32'd0);

    // Reset overrides flush and input while in SKID
    drive(1'b1, 16'h0001, 1'b0, 1'b0);
    tick();
    drive(1'b1, 16'h0002, 1'b0, 1'b0);
    tick();
    drive(1'b1, 16'h0003, 1'b0, 1'b1);
    rst = 1'b1;
    tick();
    chk("rstskid_valid", 32'(s_out_valid), 32'd0);
    chk("rstskid_in_ready", 32'(s_in_ready), 32'd1);
    chk("rstskid_data", 32'(s_out_data), 32'hBEEF);
    chk("rstskid_flush", 32'(s_flush), 32'd0);
    chk("rstskid_stall", 32'(s_stall), 32'd0);
    rst = 1'b0;

    // Single-entry: combinational in_ready and 2-bit stall saturation
    drive(1'b1, 16'h0007, 1'b0, 1'b0);
    tick();
    chk("single_load_data", 32'(o_out_data), 32'h0007);
    chk("single_held_in_ready", 32'(o_in_ready), 32'd0);
    drive(1'b0, '0, 1'b0, 1'b0);
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("single_stall_seq", 32'(o_stall), (k < 3) ? 32'(k + 1) : 32'd3);
    end
    drive(1'b1, 16'h0010, 1'b1, 1'b0);
    #1;
    chk("single_comb_in_ready", 32'(o_in_ready), 32'd1);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("single_b2b_data", 32'(o_out_data), 32'h0010 + 32'(k));
      chk("single_b2b_valid", 32'(o_out_valid), 32'd1);
      in_data = 16'(16'h0011 + k);
    end

    // Randomized traffic with varying backpressure, flushes and resets
    for (int blk = 0; blk < 6; blk++) begin
      int pv, pr;
      pv = 30 + 12 * blk;
      pr = 90 - 14 * blk;
      for (int c = 0; c < 500; c++) begin
        in_valid  = ($urandom_range(0, 99) < pv);
        in_data   = 16'($urandom);
        out_ready = ($urandom_range(0, 99) < pr);
        flush     = ($urandom_range(0, 99) < 4);
        rst       = ($urandom_range(0, 199) < 1);
        tick();
      end
    end
    drive(1'b0, '0, 1'b1, 1'b0);
    rst = 1'b0;
    tick(); tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
